// File: rtl/ring_pkg.sv
// rtl/ring_pkg.sv - shared types and constants for the ring slot arbiter
package ring_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ERROR = 2'd2
  } arb_state_t;

  localparam int ERR_CNT_W  = 8;
  localparam int RESYNC_LEN = 2;

endpackage

// File: rtl/ring_slot_arbiter_onehot_encoder.sv
// rtl/ring_slot_arbiter_onehot_encoder.sv - one-hot validity check and binary index encoder
module onehot_encoder #(
  parameter int WIDTH_REG = 8
) (
  input  logic [WIDTH_REG-1:0]         onehot,
  output logic                         valid,
  output logic [$clog2(WIDTH_REG)-1:0] idx
);

  localparam int IDX_W = $clog2(WIDTH_REG);

  // OR of set-bit positions; only meaningful when exactly one bit is hot
  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH_REG; i++) begin
      if (onehot[i]) begin
        idx = idx | i[IDX_W-1:0];
      end
    end
  end

  // x & (x-1) clears the lowest set bit, so zero means at most one bit was set
  assign valid = (onehot != '0) && ((onehot & (onehot - WIDTH_REG'(1))) == '0);

endmodule

// File: rtl/ring_slot_arbiter.sv
// rtl/ring_slot_arbiter.sv - time-division slot arbiter driven by a one-hot ring,
// with hold timeout and ring integrity checking
module ring_slot_arbiter
  import ring_pkg::*;
#(
  parameter int WIDTH_REG = 8,
  parameter int MAX_HOLD  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH_REG-1:0]         slot_onehot,
  input  logic [WIDTH_REG-1:0]         req,
  input  logic                         done,
  output logic [WIDTH_REG-1:0]         gnt,
  output logic [$clog2(WIDTH_REG)-1:0] gnt_idx,
  output logic                         gnt_valid,
  output logic                         gnt_timeout,
  output logic                         slot_err,
  output logic                         err_sticky,
  output logic [ERR_CNT_W-1:0]         err_cnt
);

  localparam int IDX_W     = $clog2(WIDTH_REG);
  localparam int HOLD_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(MAX_HOLD - 1);
  localparam logic [1:0]        RESYNC_LAST = 2'(RESYNC_LEN - 1);

  arb_state_t              state_q, state_d;
  logic [HOLD_W-1:0]       hold_cnt, hold_d;
  logic [1:0]              resync_cnt, resync_d;
  logic [WIDTH_REG-1:0]    gnt_d;
  logic [IDX_W-1:0]        idx_d;
  logic                    valid_d;
  logic                    timeout_d;
  logic                    slot_err_d;
  logic                    sticky_d;
  logic [ERR_CNT_W-1:0]    err_cnt_d;

  logic                    slot_valid;
  logic [IDX_W-1:0]        slot_idx;
  logic                    req_held;
  logic                    slot_hit;

  onehot_encoder #(
    .WIDTH_REG(WIDTH_REG)
  ) u_enc (
    .onehot(slot_onehot),
    .valid (slot_valid),
    .idx   (slot_idx)
  );

  assign req_held = |(req & gnt);
  assign slot_hit = |(req & slot_onehot);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      hold_cnt    <= '0;
      resync_cnt  <= '0;
      gnt         <= '0;
      gnt_idx     <= '0;
      gnt_valid   <= 1'b0;
      gnt_timeout <= 1'b0;
      slot_err    <= 1'b0;
      err_sticky  <= 1'b0;
      err_cnt     <= '0;
    end else begin
      state_q     <= state_d;
      hold_cnt    <= hold_d;
      resync_cnt  <= resync_d;
      gnt         <= gnt_d;
      gnt_idx     <= idx_d;
      gnt_valid   <= valid_d;
      gnt_timeout <= timeout_d;
      slot_err    <= slot_err_d;
      err_sticky  <= sticky_d;
      err_cnt     <= err_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_cnt;
    resync_d   = resync_cnt;
    gnt_d      = gnt;
    idx_d      = gnt_idx;
    valid_d    = gnt_valid;
    timeout_d  = 1'b0;
    slot_err_d = ~slot_valid;
    sticky_d   = err_sticky | ~slot_valid;
    err_cnt_d  = err_cnt;

    if (!slot_valid && (err_cnt != '1)) begin
      err_cnt_d = err_cnt + ERR_CNT_W'(1);
    end

    // a corrupt ring sample overrides whatever the current state wants to do
    if (!slot_valid) begin
      state_d  = ERROR;
      hold_d   = '0;
      resync_d = '0;
      gnt_d    = '0;
      idx_d    = '0;
      valid_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (slot_hit) begin
            state_d = GRANT;
            gnt_d   = slot_onehot;
            idx_d   = slot_idx;
            valid_d = 1'b1;
            hold_d  = '0;
          end
        end
        GRANT: begin
          if (done || !req_held || (hold_cnt == HOLD_LAST)) begin
            state_d   = IDLE;
            timeout_d = !done && req_held;
            hold_d    = '0;
            gnt_d     = '0;
            idx_d     = '0;
            valid_d   = 1'b0;
          end else begin
            hold_d = hold_cnt + HOLD_W'(1);
          end
        end
        ERROR: begin
          if (resync_cnt == RESYNC_LAST) begin
            state_d  = IDLE;
            resync_d = '0;
          end else begin
            resync_d = resync_cnt + 2'd1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ring_slot_arbiter.sv
// tb/tb_ring_slot_arbiter.sv - directed scoreboard bench for ring_slot_arbiter
module tb_ring_slot_arbiter;

  typedef struct packed {
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       vld;
    logic       to;
    logic       se;
    logic       st;
    logic [7:0] cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       done;
  logic [7:0] slot_onehot;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       gnt_timeout;
  logic       slot_err;
  logic       err_sticky;
  logic [7:0] err_cnt;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];

  ring_slot_arbiter #(
    .WIDTH_REG(8),
    .MAX_HOLD (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .slot_onehot(slot_onehot),
    .req        (req),
    .done       (done),
    .gnt        (gnt),
    .gnt_idx    (gnt_idx),
    .gnt_valid  (gnt_valid),
    .gnt_timeout(gnt_timeout),
    .slot_err   (slot_err),
    .err_sticky (err_sticky),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] idx_of(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_out();
    exp_t e;
    checks++;
    assert (exp_q.size() > 0) else begin
      errors++;
      $error("FAIL scoreboard_empty: got 0 entries expected 1");
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("gnt",         gnt,                e.gnt);
      chk("gnt_idx",     {5'd0, gnt_idx},    {5'd0, e.idx});
      chk("gnt_valid",   {7'd0, gnt_valid},  {7'd0, e.vld});
      chk("gnt_timeout", {7'd0, gnt_timeout},{7'd0, e.to});
      chk("slot_err",    {7'd0, slot_err},   {7'd0, e.se});
      chk("err_sticky",  {7'd0, err_sticky}, {7'd0, e.st});
      chk("err_cnt",     err_cnt,            e.cnt);
    end
  endtask

  // drive one cycle of inputs, record what the outputs must be after the edge
  task automatic cyc(input logic r, input logic [7:0] s, input logic [7:0] rq, input logic d,
                     input logic [7:0] eg, input logic eto, input logic ese,
                     input logic est, input logic [7:0] ec);
    exp_t e;
    rst         = r;
    slot_onehot = s;
    req         = rq;
    done        = d;
    e.gnt = eg;
    e.idx = idx_of(eg);
    e.vld = (eg != 8'h00);
    e.to  = eto;
    e.se  = ese;
    e.st  = est;
    e.cnt = ec;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    // reset state
    cyc(1, 8'h01, 8'h00, 0, 8'h00, 0, 0, 0, 8'd0);

    // basic grant released by done
    cyc(0, 8'h01, 8'h04, 0, 8'h00, 0, 0, 0, 8'd0);
    cyc(0, 8'h02, 8'h04, 0, 8'h00, 0, 0, 0, 8'd0);
    cyc(0, 8'h04, 8'h04, 0, 8'h04, 0, 0, 0, 8'd0);
    cyc(0, 8'h08, 8'h04, 0, 8'h04, 0, 0, 0, 8'd0);
    cyc(0, 8'h10, 8'h04, 1, 8'h00, 0, 0, 0, 8'd0);
    cyc(0, 8'h20, 8'h04, 0, 8'h00, 0, 0, 0, 8'd0);
    cyc(0, 8'h40, 8'h04, 0, 8'h00, 0, 0, 0, 8'd0);

    // timeout, regrant, then done coinciding with timeout
    cyc(1, 8'h01, 8'h00, 0, 8'h00, 0, 0, 0, 8'd0);
    cyc(0, 8'h01, 8'h10, 0, 8'h00, 0, 0, 0, 8'd0);
    cyc(0, 8'h02, 8'h10, 0, 8'h00, 0, 0, 0, 8'd0);
    cyc(0, 8'h04, 8'h10, 0, 8'h00, 0, 0, 0, 8'd0);
    cyc(0, 8'h08, 8'h10, 0, 8'h00, 0, 0, 0, 8'd0);
    cyc(0, 8'h10, 8'h10, 0, 8'h10, 0, 0, 0, 8'd0);
    cyc(0, 8'h20, 8'h10, 0, 8'h10, 0, 0, 0, 8'd0);
    cyc(0, 8'h40, 8'h10, 0, 8'h10, 0, 0, 0, 8'd0);
    cyc(0, 8'h80, 8'h10, 0, 8'h10, 0, 0, 0, 8'd0);
    cyc(0, 8'h01, 8'h10, 0, 8'h00, 1, 0, 0, 8'd0);
    cyc(0, 8'h02, 8'h10, 0, 8'h00, 0, 0, 0, 8'd0);
    cyc(0, 8'h04, 8'h10, 0, 8'h00, 0, 0, 0, 8'd0);
    cyc(0, 8'h08, 8'h10, 0, 8'h00, 0, 0, 0, 8'd0);
    cyc(0, 8'h10, 8'h10, 0, 8'h10, 0, 0, 0, 8'd0);
    cyc(0, 8'h20, 8'h10, 0, 8'h10, 0, 0, 0, 8'd0);
    cyc(0, 8'h40, 8'h10, 0, 8'h10, 0, 0, 0, 8'd0);
    cyc(0, 8'h80, 8'h10, 0, 8'h10, 0, 0, 0, 8'd0);
    cyc(0, 8'h01, 8'h10, 1, 8'h00, 0, 0, 0, 8'd0);
    cyc(0, 8'h02, 8'h10, 0, 8'h00, 0, 0, 0, 8'd0);

    // corrupt ring mid-grant, interrupted resync, grant on 3rd valid sample
    cyc(1, 8'h01, 8'h00, 0, 8'h00, 0, 0, 0, 8'd0);
    cyc(0, 8'h01, 8'h04, 0, 8'h00, 0, 0, 0, 8'd0);
    cyc(0, 8'h02, 8'h04, 0, 8'h00, 0, 0, 0, 8'd0);
    cyc(0, 8'h04, 8'h04, 0, 8'h04, 0, 0, 0, 8'd0);
    cyc(0, 8'h08, 8'h04, 0, 8'h04, 0, 0, 0, 8'd0);
    cyc(0, 8'h05, 8'h04, 0, 8'h00, 0, 1, 1, 8'd1);
    cyc(0, 8'h20, 8'hFF, 0, 8'h00, 0, 0, 1, 8'd1);
    cyc(0, 8'h00, 8'hFF, 0, 8'h00, 0, 1, 1, 8'd2);
    cyc(0, 8'h80, 8'hFF, 0, 8'h00, 0, 0, 1, 8'd2);
    cyc(0, 8'h01, 8'hFF, 0, 8'h00, 0, 0, 1, 8'd2);
    cyc(0, 8'h02, 8'hFF, 0, 8'h02, 0, 0, 1, 8'd2);
    cyc(0, 8'h04, 8'hFF, 0, 8'h02, 0, 0, 1, 8'd2);
    cyc(0, 8'h08, 8'hFF, 1, 8'h00, 0, 0, 1, 8'd2);

    // error counter saturation
    cyc(1, 8'h01, 8'h00, 0, 8'h00, 0, 0, 0, 8'd0);
    for (int i = 0; i < 300; i++) begin
      cyc(0, 8'h00, 8'h00, 0, 8'h00, 0, 1, 1, (i < 255) ? 8'(i + 1) : 8'd255);
    end

    // resync, grant slot 7, then reset mid-grant
    cyc(0, 8'h01, 8'h80, 0, 8'h00, 0, 0, 1, 8'd255);
    cyc(0, 8'h02, 8'h80, 0, 8'h00, 0, 0, 1, 8'd255);
    cyc(0, 8'h04, 8'h80, 0, 8'h00, 0, 0, 1, 8'd255);
    cyc(0, 8'h08, 8'h80, 0, 8'h00, 0, 0, 1, 8'd255);
    cyc(0, 8'h10, 8'h80, 0, 8'h00, 0, 0, 1, 8'd255);
    cyc(0, 8'h20, 8'h80, 0, 8'h00, 0, 0, 1, 8'd255);
    cyc(0, 8'h40, 8'h80, 0, 8'h00, 0, 0, 1, 8'd255);
    cyc(0, 8'h80, 8'h80, 0, 8'h80, 0, 0, 1, 8'd255);
    cyc(1, 8'h01, 8'h80, 0, 8'h00, 0, 0, 0, 8'd0);
    cyc(0, 8'h02, 8'h04, 0, 8'h00, 0, 0, 0, 8'd0);
    cyc(0, 8'h04, 8'h04, 0, 8'h04, 0, 0, 0, 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ring_slot_arbiter.md
# ring_slot_arbiter

Time-division slot arbiter that sits directly downstream of the one-hot ring counter. Each cycle it samples the ring's one-hot slot vector and grants the bus to the requester that owns the current slot. A grant is held until release or timeout. The block also checks ring integrity, because a corrupted ring (zero or several bits hot) is otherwise silent. On corruption it drops any grant and waits for the ring to resynchronise.

## Interface
Parameters:
- WIDTH_REG, 8: number of slots; equals the ring counter width; must be ≥ 2.
- MAX_HOLD, 4: maximum number of cycles a grant stays asserted; must be ≥ 1.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- slot_onehot  in  WIDTH_REG  current slot vector from the ring counter.
- req  in  WIDTH_REG  req[k] requests slot k; level-sensitive.
- done  in  1  the current grantee releases the bus.
- gnt  out  WIDTH_REG  one-hot grant; all zero when idle.
- gnt_idx  out  $clog2(WIDTH_REG)  binary index of the granted slot; 0 when idle.
- gnt_valid  out  1  high while a grant is held.
- gnt_timeout  out  1  one-cycle pulse when a grant ends by reaching MAX_HOLD.
- slot_err  out  1  one-cycle pulse for each invalid slot_onehot sample.
- err_sticky  out  1  set on the first error; cleared only by rst.
- err_cnt  out  8  error count; saturates at 255.

## Operation
- Slot valid: slot_onehot has exactly one bit set. It is invalid when all bits are 0 or two or more bits are 1.
- FSM states: IDLE, GRANT, ERROR. The ERROR transition has priority over every other transition.
- IDLE:
  - If the slot is invalid: go to ERROR.
  - Else if (req & slot_onehot) != 0: go to GRANT. Register gnt = slot_onehot, gnt_idx = encoded index, hold_cnt = 0.
  - Otherwise stay in IDLE.
- GRANT:
  - gnt, gnt_idx and gnt_valid stay frozen while the ring keeps rotating.
  - hold_cnt increments by 1 each cycle.
  - Exit to IDLE when done = 1, or req[gnt_idx] = 0, or hold_cnt == MAX_HOLD-1.
  - gnt_timeout pulses only on the timeout exit. If done and timeout occur in the same cycle, done wins and there is no pulse.
  - An invalid slot while in GRANT goes to ERROR and the grant is dropped.
- ERROR:
  - gnt = 0. A 2-bit resync counter counts consecutive valid slot samples and resets on any invalid sample.
  - Return to IDLE after 2 consecutive valid samples.
- Error reporting:
  - slot_err is registered: it is high in the cycle after each invalid sample, in every state.
  - err_cnt increments on every slot_err and holds at 255.
- Exiting GRANT always passes through at least one IDLE cycle. There is no back-to-back grant without that gap.
- Reset: state = IDLE. All outputs are 0: gnt, gnt_idx, gnt_valid, gnt_timeout, slot_err, err_sticky, err_cnt. hold_cnt and the resync counter are also 0. Reset mid-grant drops gnt on the next edge.

## Timing
- Grant latency is 1 cycle. If the sample at edge N has slot_onehot[k] = 1 and req[k] = 1, then gnt[k] = 1 after edge N.
- Maximum grant length is MAX_HOLD cycles of gnt_valid.
- After a release (done or req drop) sampled at edge M, gnt = 0 after edge M.
- slot_err has 1-cycle latency from the sampled input. The first ERROR-state cycle coincides with the slot_err pulse.
- Minimum ERROR duration is 2 cycles. A grant is possible on the 3rd valid sample at the earliest.
- All outputs are registered. There are no combinational paths from input to output.

## Structure
- Package ring_pkg holds:
  - typedef enum logic [1:0] {IDLE, GRANT, ERROR} arb_state_t
  - localparam ERR_CNT_W = 8
  - localparam RESYNC_LEN = 2
- Sub-module onehot_encoder is combinational, parameterised by WIDTH_REG. Outputs: valid (exactly one bit hot) and idx (binary index). One instance is used.
- Expected size of the top level is roughly 150–250 lines.

## Test plan
All scenarios use WIDTH_REG = 8 and MAX_HOLD = 4.
- Basic grant: ring rotating from 8'h01, req = 8'h04, done pulsed 2 cycles after grant. Expect gnt = 8'h04 and gnt_idx = 2 one cycle after slot 8'h04, held for 2 cycles, then 0 for at least 1 cycle.
- Timeout: req = 8'h10 held high, done = 0. Expect gnt = 8'h10 for exactly 4 cycles, a single gnt_timeout pulse on the exit, and a regrant when slot 8'h10 next comes around.
- Done and timeout together: done = 1 in the 4th grant cycle. Expect the grant to end with gnt_timeout = 0.
- Corrupt ring:
  - Force slot_onehot = 8'h05 mid-grant. Expect gnt = 0, slot_err pulse, err_sticky = 1, err_cnt = 1.
  - Then 1 valid, 1 invalid, 2 valid samples. Expect ERROR held until the 2nd consecutive valid sample, and err_cnt = 2.
- Saturation: 300 cycles of slot_onehot = 8'h00. Expect err_cnt = 255 with no wrap.
- Reset mid-grant: assert rst for 1 cycle while gnt = 8'h80. Expect all outputs 0 on the next edge, err_sticky cleared, and state IDLE.
